// File: rtl/vertex_apply_pkg.sv
// Shared types for the vertex apply stage: FSM encoding, default widths and
// the per-lane update record used at the input edge.
package vertex_apply_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      CLEAR,
      ACCUM,
      FLUSH,
      DRAIN
   } state_e;

   typedef struct packed {
      logic                  valid;
      logic [DEF_DATA_W-1:0] vid;
      logic [DEF_DATA_W-1:0] update;
   } lane_rec_t;

endpackage

// File: rtl/vertex_apply_buf_2p.sv
// Vertex value storage: two write ports, two synchronous read ports,
// read-before-write on same-edge collisions, no reset on the array.
module vertex_buf_2p #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rdEnA_i,
   input  logic [ADDR_W-1:0] rdAddrA_i,
   input  logic [ADDR_W-1:0] rdAddrB_i,
   output logic [DATA_W-1:0] rdDataA_o,
   output logic [DATA_W-1:0] rdDataB_o,
   input  logic              weA_i,
   input  logic [ADDR_W-1:0] wrAddrA_i,
   input  logic [DATA_W-1:0] wrDataA_i,
   input  logic              weB_i,
   input  logic [ADDR_W-1:0] wrAddrB_i,
   input  logic [DATA_W-1:0] wrDataB_i
);

   logic [DATA_W-1:0] mem [1<<ADDR_W];
   logic [DATA_W-1:0] rdDataA_q;
   logic [DATA_W-1:0] rdDataB_q;

   // Port A read can be held so a stalled drain word stays put.
   always_ff @(posedge clk_i) begin
      if (rdEnA_i) rdDataA_q <= mem[rdAddrA_i];
      rdDataB_q <= mem[rdAddrB_i];
      if (weA_i) mem[wrAddrA_i] <= wrDataA_i;
      if (weB_i) mem[wrAddrB_i] <= wrDataB_i;
   end

   assign rdDataA_o = rdDataA_q;
   assign rdDataB_o = rdDataB_q;

endmodule

// File: rtl/vertex_apply.sv
// Accumulates two-lane (vid, update) pairs into the vertex buffer with a
// 2-stage read-modify-write pipeline, then drains and zeroes it on request.
module vertex_apply
   import vertex_apply_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              InValid_A,
   input  logic              InValid_B,
   input  logic [DATA_W-1:0] InDestVid_A,
   input  logic [DATA_W-1:0] InDestVid_B,
   input  logic [DATA_W-1:0] InUpdate_A,
   input  logic [DATA_W-1:0] InUpdate_B,
   output logic              in_ready,
   input  logic              drain_req,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_vid,
   output logic [DATA_W-1:0] out_value,
   output logic              drain_done,
   output logic [CNT_W-1:0]  drop_cnt
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] update;
   } stage_t;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   ptr_q, ptr_d;
   stage_t            s1A_q, s1B_q, s2A_q, s2B_q, wrA_q, wrB_q;
   stage_t            s1A_d, s1B_d;
   logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;
   logic [CNT_W:0]    dropSum;
   logic              outValid_q, outValid_d;
   logic [ADDR_W-1:0] outIdx_q;
   logic              drainDone_q;
   lane_rec_t         laneA, laneB;
   logic              inRangeA, inRangeB, dropA, dropB, merge;
   logic              load, lastHs;
   logic              rdEnA, weA, weB;
   logic [ADDR_W-1:0] rdAddrA, wrAddrA;
   logic [DATA_W-1:0] rdDataA, rdDataB, wrDataA, sumA, sumB;

   assign in_ready = (state_q == ACCUM);
   assign laneA = '{valid: InValid_A && in_ready, vid: InDestVid_A, update: InUpdate_A};
   assign laneB = '{valid: InValid_B && in_ready, vid: InDestVid_B, update: InUpdate_B};
   assign inRangeA = laneA.valid && (laneA.vid[DATA_W-1:ADDR_W] == '0);
   assign inRangeB = laneB.valid && (laneB.vid[DATA_W-1:ADDR_W] == '0);
   assign dropA = laneA.valid && !inRangeA;
   assign dropB = laneB.valid && !inRangeB;
   assign merge = inRangeA && inRangeB && (laneA.vid == laneB.vid);

   // Merging equal vids at the input keeps the two S2 write addresses distinct.
   always_comb begin
      s1A_d = '{valid: inRangeA, addr: laneA.vid[ADDR_W-1:0],
                update: merge ? laneA.update + laneB.update : laneA.update};
      s1B_d = '{valid: inRangeB && !merge, addr: laneB.vid[ADDR_W-1:0], update: laneB.update};
      dropSum = {1'b0, dropCnt_q} + (CNT_W+1)'(dropA) + (CNT_W+1)'(dropB);
      dropCnt_d = dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
   end

   // The read was sampled on the same edge as last cycle's write, so that write is forwarded.
   function automatic logic [DATA_W-1:0] pickBase(input stage_t s, input stage_t pa,
                                                  input stage_t pb, input logic [DATA_W-1:0] rd);
      if (pa.valid && pa.addr == s.addr) return pa.update;
      if (pb.valid && pb.addr == s.addr) return pb.update;
      return rd;
   endfunction

   assign sumA = pickBase(s2A_q, wrA_q, wrB_q, rdDataA) + s2A_q.update;
   assign sumB = pickBase(s2B_q, wrA_q, wrB_q, rdDataB) + s2B_q.update;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      load       = 1'b0;
      lastHs     = 1'b0;
      outValid_d = outValid_q;
      case (state_q)
         CLEAR: begin
            ptr_d = ptr_q + (ADDR_W+1)'(1);
            if (ptr_q[ADDR_W-1:0] == '1) begin
               ptr_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: if (drain_req) state_d = FLUSH;
         FLUSH: begin
            ptr_d = ptr_q + (ADDR_W+1)'(1);
            if (ptr_q[0]) begin
               ptr_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            load   = !ptr_q[ADDR_W] && (!outValid_q || out_ready);
            lastHs = ptr_q[ADDR_W] && outValid_q && out_ready;
            if (load) ptr_d = ptr_q + (ADDR_W+1)'(1);
            if (load) outValid_d = 1'b1;
            else if (out_ready) outValid_d = 1'b0;
            if (lastHs) begin
               ptr_d   = '0;
               state_d = ACCUM;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1A_q       <= '0;
         s1B_q       <= '0;
         s2A_q       <= '0;
         s2B_q       <= '0;
         wrA_q       <= '0;
         wrB_q       <= '0;
         dropCnt_q   <= '0;
         outValid_q  <= 1'b0;
         outIdx_q    <= '0;
         drainDone_q <= 1'b0;
      end else begin
         s1A_q       <= s1A_d;
         s1B_q       <= s1B_d;
         s2A_q       <= s1A_q;
         s2B_q       <= s1B_q;
         wrA_q       <= '{valid: s2A_q.valid, addr: s2A_q.addr, update: sumA};
         wrB_q       <= '{valid: s2B_q.valid, addr: s2B_q.addr, update: sumB};
         dropCnt_q   <= dropCnt_d;
         outValid_q  <= outValid_d;
         drainDone_q <= lastHs;
         if (load) outIdx_q <= ptr_q[ADDR_W-1:0];
      end
   end

   // Port A is shared: zero-fill in CLEAR, read-and-zero in DRAIN, S2 lane A otherwise.
   always_comb begin
      rdEnA   = (state_q != DRAIN) || load;
      rdAddrA = (state_q == DRAIN) ? ptr_q[ADDR_W-1:0] : s1A_q.addr;
      weA     = s2A_q.valid;
      wrAddrA = s2A_q.addr;
      wrDataA = sumA;
      if (state_q == CLEAR || state_q == DRAIN) begin
         weA     = (state_q == CLEAR) || load;
         wrAddrA = ptr_q[ADDR_W-1:0];
         wrDataA = '0;
      end
      weB = s2B_q.valid;
   end

   vertex_buf_2p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf (
      .clk_i     (clk),
      .rdEnA_i   (rdEnA),
      .rdAddrA_i (rdAddrA),
      .rdAddrB_i (s1B_q.addr),
      .rdDataA_o (rdDataA),
      .rdDataB_o (rdDataB),
      .weA_i     (weA),
      .wrAddrA_i (wrAddrA),
      .wrDataA_i (wrDataA),
      .weB_i     (weB),
      .wrAddrB_i (s2B_q.addr),
      .wrDataB_i (sumB)
   );

   assign out_valid  = outValid_q;
   assign out_vid    = {{(DATA_W-ADDR_W){1'b0}}, outIdx_q};
   assign out_value  = outValid_q ? rdDataA : '0;
   assign drain_done = drainDone_q;
   assign drop_cnt   = dropCnt_q;

endmodule

// File: tb/tb_vertex_apply.sv
// Randomized self-checking bench for vertex_apply against an array-of-sums
// reference; drained words are compared as they are handed off.
module tb_vertex_apply;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int CW    = 16;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          InValid_A = 1'b0, InValid_B = 1'b0;
   logic [DW-1:0] InDestVid_A = '0, InDestVid_B = '0;
   logic [DW-1:0] InUpdate_A = '0, InUpdate_B = '0;
   logic          in_ready;
   logic          drain_req = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_vid, out_value;
   logic          drain_done;
   logic [CW-1:0] drop_cnt;

   always #5 clk = ~clk;

   vertex_apply #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .InValid_A   (InValid_A),
      .InValid_B   (InValid_B),
      .InDestVid_A (InDestVid_A),
      .InDestVid_B (InDestVid_B),
      .InUpdate_A  (InUpdate_A),
      .InUpdate_B  (InUpdate_B),
      .in_ready    (in_ready),
      .drain_req   (drain_req),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_vid     (out_vid),
      .out_value   (out_value),
      .drain_done  (drain_done),
      .drop_cnt    (drop_cnt)
   );

   int unsigned model [DEPTH];
   int unsigned drained [DEPTH];
   int unsigned dropsModel = 0;
   int          total = 0;
   int          bad = 0;
   int          expIdx = DEPTH;
   int          doneSeen = 0;
   logic        stalledPrev = 1'b0;
   logic        donePrev = 1'b0;
   logic [DW-1:0] heldVid, heldVal;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic void modelLane(input logic v, input logic [DW-1:0] vid, input logic [DW-1:0] upd);
      if (!v) return;
      if (vid < DEPTH) model[vid] += upd;
      else if (dropsModel < 65535) dropsModel++;
   endfunction

   function automatic void clearModel();
      for (int i = 0; i < DEPTH; i++) model[i] = 0;
      dropsModel = 0;
   endfunction

   task automatic applyStimulus(input logic va, input logic [DW-1:0] vidA, input logic [DW-1:0] upA,
                                input logic vb, input logic [DW-1:0] vidB, input logic [DW-1:0] upB);
      @(posedge clk); #1;
      InValid_A = va; InDestVid_A = vidA; InUpdate_A = upA;
      InValid_B = vb; InDestVid_B = vidB; InUpdate_B = upB;
      if (in_ready) begin
         modelLane(va, vidA, upA);
         modelLane(vb, vidB, upB);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         InValid_A = 1'b0;
         InValid_B = 1'b0;
      end
   endtask

   // mode 0: always ready, 1: toggle each cycle, 2: random
   task automatic doDrain(input int mode);
      int start;
      @(posedge clk); #1;
      InValid_A = 1'b0; InValid_B = 1'b0;
      drain_req = 1'b1;
      expIdx = 0;
      start = doneSeen;
      @(posedge clk); #1;
      drain_req = 1'b0;
      for (int c = 0; c < 3000 && doneSeen == start; c++) begin
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2 == 0) : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      if (doneSeen == start) checkOutput("drain_timeout", 0, 1);
      checkOutput("drain_count", expIdx, DEPTH);
   endtask

   task automatic waitClear(input string name);
      int cnt = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (in_ready) break;
         cnt++;
      end
      checkOutput(name, cnt, DEPTH);
      checkOutput({name, "_ready"}, in_ready, 1);
   endtask

   // Every handshake must deliver the next index with its accumulated sum.
   always @(negedge clk) begin
      if (rst) begin
         if (stalledPrev) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_vid", out_vid, heldVid);
            checkOutput("stall_value", out_value, heldVal);
         end
         if (out_valid && out_ready) begin
            if (expIdx >= DEPTH) checkOutput("drain_overrun", expIdx, DEPTH - 1);
            else begin
               checkOutput("drain_vid", out_vid, expIdx);
               checkOutput("drain_value", out_value, model[expIdx]);
               drained[expIdx] = out_value;
               model[expIdx] = 0;
               expIdx++;
            end
         end
         stalledPrev = out_valid && !out_ready;
         heldVid = out_vid;
         heldVal = out_value;
         if (donePrev) checkOutput("done_pulse_width", drain_done, 0);
         if (drain_done) begin
            checkOutput("done_after_last", expIdx, DEPTH);
            doneSeen++;
         end
         donePrev = drain_done;
      end else begin
         stalledPrev = 1'b0;
         donePrev = 1'b0;
      end
   end

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DW-1:0] va, vb;
      clearModel();
      repeat (3) @(posedge clk);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_vid", out_vid, 0);
      checkOutput("rst_out_value", out_value, 0);
      checkOutput("rst_drain_done", drain_done, 0);
      checkOutput("rst_drop_cnt", drop_cnt, 0);
      #1 rst = 1'b1;

      waitClear("clear_cycles");
      doDrain(0);
      checkOutput("t1_idx0", drained[0], 0);
      checkOutput("t1_idx255", drained[255], 0);

      applyStimulus(1, 5, 3, 1, 9, 4);
      idle(3);
      doDrain(0);
      checkOutput("t2_idx5", drained[5], 3);
      checkOutput("t2_idx9", drained[9], 4);
      checkOutput("t2_idx6", drained[6], 0);

      applyStimulus(1, 7, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 7, 2);
      applyStimulus(1, 7, 4, 0, 0, 0);
      idle(1);
      applyStimulus(1, 3, 10, 1, 3, 20);
      idle(3);
      doDrain(1);
      checkOutput("t3_idx7", drained[7], 7);
      checkOutput("t4_idx3", drained[3], 30);
      doDrain(0);
      checkOutput("t6_second_idx7", drained[7], 0);

      applyStimulus(1, 256, 5, 1, 1000, 7);
      idle(2);
      checkOutput("t5_drop_two", drop_cnt, 2);
      doDrain(0);

      for (int c = 0; c < 600; c++) begin
         int r;
         r = $urandom_range(0, 9);
         va = (r < 5) ? $urandom_range(0, 7) : (r < 9) ? $urandom_range(0, DEPTH - 1) : $urandom_range(DEPTH, 5000);
         r = $urandom_range(0, 9);
         vb = (r < 5) ? $urandom_range(0, 7) : (r < 9) ? $urandom_range(0, DEPTH - 1) : $urandom_range(DEPTH, 5000);
         applyStimulus(1'($urandom_range(0, 3) != 0), va, $urandom,
                       1'($urandom_range(0, 3) != 0), vb, $urandom);
      end
      idle(3);
      checkOutput("rand_drop_cnt", drop_cnt, dropsModel);
      doDrain(2);

      for (int c = 0; c < 35000; c++) applyStimulus(1, 256 + c, 1, 1, 32'hFFFF_0000, 1);
      idle(2);
      checkOutput("sat_drop_cnt", drop_cnt, 65535);
      checkOutput("sat_drop_model", drop_cnt, dropsModel);
      doDrain(0);

      applyStimulus(1, 11, 5, 1, 12, 6);
      applyStimulus(1, 300, 5, 0, 0, 0);
      idle(1);
      #2 rst = 1'b0;
      #1;
      clearModel();
      checkOutput("mid_rst_in_ready", in_ready, 0);
      checkOutput("mid_rst_drop_cnt", drop_cnt, 0);
      checkOutput("mid_rst_out_valid", out_valid, 0);
      @(posedge clk); #1 rst = 1'b1;
      waitClear("reclear_cycles");
      doDrain(0);
      checkOutput("mid_rst_idx11", drained[11], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
